// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and helper functions.
// The parity helper is shared with the TX serializer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest payload the parity helper accepts; narrower words are zero-extended.
    localparam int PAR_MAX_W = 64;

    function automatic logic expected_parity(input logic [PAR_MAX_W-1:0] data,
                                             input logic                 par_typ);
        return (^data) ^ par_typ;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Bundle between the RX line/controller side (master) and the deserializer (slave).
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_in;
    logic                  par_en;
    logic                  par_typ;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output rx_in, par_en, par_typ,
        input  p_data, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  rx_in, par_en, par_typ,
        output p_data, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchronizer plus bit decision; UART_RX_MAJORITY_EN selects a 3-tick
// majority vote decided at tick OVERSAMPLE/2+1 instead of a single sample at OVERSAMPLE/2.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int TICK_W     = $clog2(OVERSAMPLE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    input  logic [TICK_W-1:0] tick_i,
    output logic              rx_s_o,
    output logic              bit_o,
    output logic              stb_o
);
    localparam int D = OVERSAMPLE / 2;

    logic [1:0] sync_q, sync_d;

    assign sync_d = {sync_q[0], rx_i};
    assign rx_s_o = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= sync_d;
    end

`ifdef UART_RX_MAJORITY_EN
    // hist_q[1] holds rx_s from tick D-1 and hist_q[0] from tick D when tick_i == D+1.
    logic [1:0] hist_q, hist_d;

    assign hist_d = {hist_q[0], rx_s_o};
    assign bit_o  = majority3(hist_q[1], hist_q[0], rx_s_o);
    assign stb_o  = (tick_i == TICK_W'(D + 1));

    always_ff @(posedge clk) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= hist_d;
    end
`else
    assign bit_o = rx_s_o;
    assign stb_o = (tick_i == TICK_W'(D));
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start detect, mid-bit sampling, LSB-first reassembly, parity/stop check.
// Build option UART_RX_MAJORITY_EN moves every bit decision one tick later (3-sample vote).
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input logic                   clk,
    input logic                   rst,
    uart_rx_deserializer_if.slave bus
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] START  = ST_START;
    localparam logic [2:0] DATA   = ST_DATA;
    localparam logic [2:0] PARITY = ST_PARITY;
    localparam logic [2:0] STOP   = ST_STOP;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH:0]   shift_ext;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic rx_s, bit_val, bit_stb;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .TICK_W     (TICK_W)
    ) u_sampler (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (bus.rx_in),
        .tick_i (tick_q),
        .rx_s_o (rx_s),
        .bit_o  (bit_val),
        .stb_o  (bit_stb)
    );

    assign shift_ext = {bit_val, shift_q};

    always_comb begin
        state_d   = state_q;
        tick_d    = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        p_data_d  = p_data_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // The detect cycle is tick 0 of the start bit, so counting resumes at 1.
                tick_d = '0;
                if (!rx_s) begin
                    state_d   = START;
                    tick_d    = TICK_W'(1);
                    par_en_d  = bus.par_en;
                    par_typ_d = bus.par_typ;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (bit_stb && bit_val) begin
                    state_d = IDLE;
                end else if (tick_q == TICK_LAST) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_stb) shift_d = shift_ext[DATA_WIDTH:1];
                if (tick_q == TICK_LAST) begin
                    if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
                    else                       bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_stb)
                    par_bad_d = (bit_val != expected_parity(PAR_MAX_W'(shift_q), par_typ_q));
                if (tick_q == TICK_LAST) state_d = STOP;
            end
            STOP: begin
                // Leave half a bit early so a back-to-back start edge is not missed.
                if (bit_stb) begin
                    state_d = IDLE;
                    if (!bit_val || par_bad_q) begin
                        stp_err_d = !bit_val;
                        par_err_d = par_bad_q;
                    end else begin
                        p_data_d = shift_q;
                        valid_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            par_bad_q <= 1'b0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            p_data_q  <= p_data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign bus.p_data     = p_data_q;
    assign bus.data_valid = valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed self-checking bench for uart_rx_deserializer (8-bit payload, 16x oversampling).
// Frame start cycle c = cycle rx_in first goes low; the synchronizer puts t0 at c+2.
module tb_uart_rx_deserializer;

`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    uart_rx_deserializer_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_deserializer #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled mid-cycle on the falling edge.
    int   dv_cnt, dv_cyc, dv_prev_cyc, pe_cnt, pe_cyc, se_cnt, se_cyc, busy_rise, busy_fall;
    logic busy_prev = 1'b0;

    task automatic clr_mon();
        dv_cnt = 0; dv_cyc = -1; dv_prev_cyc = -1;
        pe_cnt = 0; pe_cyc = -1; se_cnt = 0; se_cyc = -1;
        busy_rise = -1; busy_fall = -1;
    endtask

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin dv_cnt++; dv_prev_cyc = dv_cyc; dv_cyc = cyc; end
        if (bus.par_err === 1'b1) begin pe_cnt++; pe_cyc = cyc; end
        if (bus.stp_err === 1'b1) begin se_cnt++; se_cyc = cyc; end
        if (bus.busy === 1'b1 && !busy_prev && busy_rise < 0) busy_rise = cyc;
        if (bus.busy === 1'b0 && busy_prev && busy_fall < 0) busy_fall = cyc;
        busy_prev = (bus.busy === 1'b1);
    end

    // Called at #1 after a rising edge; returns at #1 after the n-th following edge.
    task automatic drive(input logic v, input int n);
        bus.rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, output int c);
        c = cyc;
        drive(1'b0, OS);
        for (int i = 0; i < 8; i++) drive(d[i], OS);
        if (pe) drive(pb, OS);
        drive(sb, OS);
    endtask

    int c0, c1;

    initial begin
        bus.rx_in = 1'b0; bus.par_en = 1'b0; bus.par_typ = 1'b0;
        clr_mon();

        // Reset with rx_in toggling.
        @(posedge clk); #1 bus.rx_in = 1'b1;
        @(posedge clk); #1 bus.rx_in = 1'b0;
        check_eq("rst_p_data", 32'(bus.p_data), 32'h00);
        check_eq("rst_valid", 32'(bus.data_valid), 0);
        check_eq("rst_par_err", 32'(bus.par_err), 0);
        check_eq("rst_stp_err", 32'(bus.stp_err), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        bus.rx_in = 1'b1;
        rst = 1'b0;
        drive(1'b1, 20);
        check_eq("idle_busy", 32'(bus.busy), 0);

        // 8N1 frame 0xA9.
        clr_mon();
        send_frame(8'hA9, 1'b0, 1'b0, 1'b1, c0);
        drive(1'b1, 20);
        $display("frame 8N1 data=a9 start=%0d valid_at=%0d", c0, dv_cyc);
        check_eq("a9_dv_cnt", 32'(dv_cnt), 1);
        check_eq("a9_dv_cyc", 32'(dv_cyc - c0), 32'(2 + 153 + LAT));
        check_eq("a9_p_data", 32'(bus.p_data), 32'hA9);
        check_eq("a9_errs", 32'(pe_cnt + se_cnt), 0);
        check_eq("a9_busy_rise", 32'(busy_rise - c0), 3);

        // 8E1, correct parity bit 0.
        clr_mon();
        bus.par_en = 1'b1; bus.par_typ = 1'b0;
        send_frame(8'hA9, 1'b1, 1'b0, 1'b1, c0);
        drive(1'b1, 20);
        $display("frame 8E1 data=a9 par=0 start=%0d valid_at=%0d", c0, dv_cyc);
        check_eq("par_ok_dv_cnt", 32'(dv_cnt), 1);
        check_eq("par_ok_dv_cyc", 32'(dv_cyc - c0), 32'(2 + 169 + LAT));
        check_eq("par_ok_p_data", 32'(bus.p_data), 32'hA9);
        check_eq("par_ok_pe_cnt", 32'(pe_cnt), 0);

        // 8E1, wrong parity bit 1.
        clr_mon();
        send_frame(8'hA9, 1'b1, 1'b1, 1'b1, c0);
        drive(1'b1, 20);
        $display("frame 8E1 data=a9 par=1 start=%0d par_err_at=%0d", c0, pe_cyc);
        check_eq("par_bad_pe_cnt", 32'(pe_cnt), 1);
        check_eq("par_bad_pe_cyc", 32'(pe_cyc - c0), 32'(2 + 169 + LAT));
        check_eq("par_bad_dv_cnt", 32'(dv_cnt), 0);
        check_eq("par_bad_se_cnt", 32'(se_cnt), 0);

        // 8O1, 0x3C has four ones so the odd parity bit is 1.
        clr_mon();
        bus.par_typ = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, c0);
        drive(1'b1, 20);
        $display("frame 8O1 data=3c par=1 start=%0d valid_at=%0d", c0, dv_cyc);
        check_eq("odd_dv_cnt", 32'(dv_cnt), 1);
        check_eq("odd_p_data", 32'(bus.p_data), 32'h3C);
        bus.par_en = 1'b0; bus.par_typ = 1'b0;

        // Stop bit 0 on 0x55; restore A9 as the held word first.
        send_frame(8'hA9, 1'b0, 1'b0, 1'b1, c0);
        drive(1'b1, 20);
        clr_mon();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, c0);
        drive(1'b1, 40);
        $display("frame 8N1 data=55 stop=0 start=%0d stp_err_at=%0d", c0, se_cyc);
        check_eq("stp_se_cnt", 32'(se_cnt), 1);
        check_eq("stp_se_cyc", 32'(se_cyc - c0), 32'(2 + 153 + LAT));
        check_eq("stp_dv_cnt", 32'(dv_cnt), 0);
        check_eq("stp_p_data", 32'(bus.p_data), 32'hA9);

        // Start glitch: 4 cycles low.
        clr_mon();
        c0 = cyc;
        drive(1'b0, 4);
        drive(1'b1, 30);
        $display("glitch start=%0d busy_fall=%0d", c0, busy_fall);
        check_eq("glitch_busy_fall", 32'(busy_fall - c0), 32'(2 + 9 + LAT));
        check_eq("glitch_pulses", 32'(dv_cnt + pe_cnt + se_cnt), 0);
        clr_mon();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, c0);
        drive(1'b1, 20);
        $display("frame 8N1 data=3c start=%0d valid_at=%0d", c0, dv_cyc);
        check_eq("post_glitch_dv_cnt", 32'(dv_cnt), 1);
        check_eq("post_glitch_p_data", 32'(bus.p_data), 32'h3C);

        // Back-to-back 0x01 then 0xFF.
        clr_mon();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, c0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, c1);
        drive(1'b1, 20);
        $display("b2b data=01,ff valid_at=%0d,%0d", dv_prev_cyc, dv_cyc);
        check_eq("b2b_dv_cnt", 32'(dv_cnt), 2);
        check_eq("b2b_gap", 32'(dv_cyc - dv_prev_cyc), 160);
        check_eq("b2b_p_data", 32'(bus.p_data), 32'hFF);

        // Back-to-back again, reset during the second frame's data bits.
        clr_mon();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, c0);
        drive(1'b0, OS);
        drive(1'b1, 3 * OS);
        rst = 1'b1;
        drive(1'b1, 1);
        check_eq("mid_rst_busy", 32'(bus.busy), 0);
        check_eq("mid_rst_p_data", 32'(bus.p_data), 32'h00);
        rst = 1'b0;
        drive(1'b1, 6 * OS);
        drive(1'b1, 20);
        $display("b2b_rst data=01,ff(aborted) valid_count=%0d", dv_cnt);
        check_eq("mid_rst_dv_cnt", 32'(dv_cnt), 1);
        check_eq("mid_rst_dv_cyc", 32'(dv_cyc - c0), 32'(2 + 153 + LAT));
        check_eq("mid_rst_errs", 32'(pe_cnt + se_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
